// File: rtl/ip_reg_pkg.sv
// ip_reg_pkg: shared types and defaults for the register-access responder, its initiator and bench.
package ip_reg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_REGS_DEF = 8;
  localparam logic [31:0] ID_VALUE_DEF = 32'h1D0C_0001;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef struct packed {
    logic                      write;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     wdata;
    logic [DATA_W_DEF/8-1:0]   be;
  } req_t;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } rsp_t;
endpackage

// File: rtl/ip_reg_file.sv
// ip_reg_file: read-only ID at reg 0, byte-enabled scratch regs above it, plus the access error flag.
module ip_reg_file
  import ip_reg_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 NUM_REGS = NUM_REGS_DEF,
  parameter logic [DATA_W-1:0]  ID_VALUE = ID_VALUE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                is_write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  assign err = (int'(addr) >= NUM_REGS) || (is_write && addr == '0);
  always_comb begin
    regs_d = regs_q;
    rdata = (addr == '0) ? ID_VALUE : '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(addr) == i) rdata = regs_q[i];
      for (int b = 0; b < DATA_W/8; b++)
        if (we && int'(addr) == i && be[b]) regs_d[i][b*8 +: 8] = wdata[b*8 +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
endmodule

// File: rtl/ip_reg_responder.sv
// ip_reg_responder: one-at-a-time register access target with optional wait states.
module ip_reg_responder
  import ip_reg_pkg::*;
#(
  parameter int                 DATA_W      = DATA_W_DEF,
  parameter int                 ADDR_W      = ADDR_W_DEF,
  parameter int                 NUM_REGS    = NUM_REGS_DEF,
  parameter int                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]  ID_VALUE    = ID_VALUE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic                started_q, started_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rf_rdata;
  logic                rf_err, rf_we;
  // started_q keeps req_ready low for the first cycle after reset release
  assign req_ready = (state_q == IDLE) && started_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign rf_we = (state_q == ACCESS) && (wait_q == '0) && wr_q && !rf_err;
  ip_reg_file #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)
  ) u_file (
    .clk(clk), .rst_n(rst_n), .we(rf_we), .is_write(wr_q), .addr(addr_q),
    .wdata(wdata_q), .be(be_q), .rdata(rf_rdata), .err(rf_err)
  );
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    started_d = 1'b1;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rdata_d = rdata_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (req_valid && req_ready) begin
        wr_d = req_write;
        addr_d = req_addr;
        wdata_d = req_wdata;
        be_d = req_be;
        wait_d = WAIT_INIT;
        state_d = ACCESS;
      end
      ACCESS: if (wait_q != '0) wait_d = wait_q - 1'b1;
      else begin
        rdata_d = (wr_q || rf_err) ? '0 : rf_rdata;
        err_d = rf_err;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q <= '0;
      started_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      started_q <= started_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ip_reg_responder.sv
// tb_ip_reg_responder: directed and random checks on a zero-wait and a three-wait responder.
module tb_ip_reg_responder;
  import ip_reg_pkg::*;
  localparam logic [31:0] ID = 32'h1D0C_0001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid [2], req_write [2], req_ready [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [3:0] req_addr [2], req_be [2];
  logic [31:0] req_wdata [2], rsp_rdata [2];
  logic pv [2], pr [2], pe [2];
  logic [31:0] pd [2];
  logic [31:0] model [2][8];
  logic [31:0] rd, ed, d;
  logic er, ee, wr;
  logic [3:0] a, be;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ip_reg_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  ip_reg_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // handshake monitor: settles 2 time units after the drive edge
  always @(negedge clk) begin
    #2;
    for (int s = 0; s < 2; s++) begin
      check("ready_with_valid", 32'(req_ready[s] & rsp_valid[s]), 32'd0);
      if (rst_n && pv[s] && !pr[s]) begin
        check("hold_valid", 32'(rsp_valid[s]), 32'd1);
        check("hold_rdata", rsp_rdata[s], pd[s]);
        check("hold_err", 32'(rsp_err[s]), 32'(pe[s]));
      end
      pv[s] = rsp_valid[s];
      pr[s] = rsp_ready[s];
      pd[s] = rsp_rdata[s];
      pe[s] = rsp_err[s];
    end
  end
  task automatic txn(input int s, input logic w, input logic [3:0] ad, input logic [31:0] dt,
                     input logic [3:0] bm, input int hold, output logic [31:0] rdo, output logic ero);
    int n = 0;
    req_valid[s] = 1'b1;
    req_write[s] = w;
    req_addr[s] = ad;
    req_wdata[s] = dt;
    req_be[s] = bm;
    rsp_ready[s] = 1'b0;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready[s]), 32'd1);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_write[s] = ~w;
    req_addr[s] = ~ad;
    req_wdata[s] = ~dt;
    req_be[s] = ~bm;
    n = 0;
    while (!rsp_valid[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, (s == 1) ? 32'd4 : 32'd1);
    rdo = rsp_rdata[s];
    ero = rsp_err[s];
    repeat (hold) begin
      @(negedge clk);
      check("ready_while_pending", 32'(req_ready[s]), 32'd0);
    end
    check("rdata_after_hold", rsp_rdata[s], rdo);
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    check("valid_drop", 32'(rsp_valid[s]), 32'd0);
    check("ready_back", 32'(req_ready[s]), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_addr[s] = '0;
      req_wdata[s] = '0;
      req_be[s] = '0;
      rsp_ready[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_req_ready", 32'(req_ready[s]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      check("rst_rdata", rsp_rdata[s], 32'd0);
      check("rst_err", 32'(rsp_err[s]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 4'd0, 32'd0, 4'd0, 0, rd, er);
    check("id_rdata", rd, ID);
    check("id_err", 32'(er), 32'd0);
    txn(0, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    check("wr3_rdata", rd, 32'd0);
    check("wr3_err", 32'(er), 32'd0);
    txn(0, 1'b0, 4'd3, 32'd0, 4'd0, 0, rd, er);
    check("rd3_rdata", rd, 32'h00BB_00DD);
    check("rd3_err", 32'(er), 32'd0);
    txn(0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("wr0_err", 32'(er), 32'd1);
    check("wr0_rdata", rd, 32'd0);
    txn(0, 1'b0, 4'd9, 32'd0, 4'd0, 0, rd, er);
    check("rd9_err", 32'(er), 32'd1);
    check("rd9_rdata", rd, 32'd0);
    txn(0, 1'b0, 4'd0, 32'd0, 4'd0, 0, rd, er);
    check("id_again", rd, ID);
    txn(1, 1'b1, 4'd1, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    check("w3_wr1_err", 32'(er), 32'd0);
    txn(1, 1'b0, 4'd1, 32'd0, 4'd0, 4, rd, er);
    check("w3_rd1_rdata", rd, 32'hCAFE_F00D);
    check("w3_rd1_err", 32'(er), 32'd0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0] = 4'd2;
    req_wdata[0] = 32'h1234_5678;
    req_be[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("abort_in_access", 32'(rsp_valid[0] | req_ready[0]), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_abort", 32'(rsp_valid[0]), 32'd0);
    end
    txn(0, 1'b0, 4'd2, 32'd0, 4'd0, 0, rd, er);
    check("abort_lost_write", rd, 32'd0);
    txn(0, 1'b0, 4'd3, 32'd0, 4'd0, 0, rd, er);
    check("rst_cleared_reg3", rd, 32'd0);
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++) model[s][r] = '0;
    for (int i = 0; i < 1000; i++) begin
      automatic int s = i % 2;
      repeat ($urandom_range(0, 2)) begin
        req_addr[s] = 4'($urandom);
        req_write[s] = 1'($urandom);
        rsp_ready[s] = 1'($urandom);
        @(negedge clk);
      end
      wr = 1'($urandom);
      a = 4'($urandom);
      d = $urandom;
      be = 4'($urandom);
      if (a >= 4'd8) begin
        ee = 1'b1;
        ed = '0;
      end else if (wr) begin
        ee = (a == 4'd0);
        ed = '0;
        if (a != 4'd0)
          for (int b = 0; b < 4; b++) if (be[b]) model[s][a[2:0]][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        ee = 1'b0;
        ed = (a == 4'd0) ? ID : model[s][a[2:0]];
      end
      txn(s, wr, a, d, be, int'($urandom_range(0, 3)), rd, er);
      check("rnd_rdata", rd, ed);
      check("rnd_err", 32'(er), 32'(ee));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
